// File: rtl/rob_commit.sv
// In-order ROB retirement stage: retires at most one head entry per cycle,
// driving the register-file write, the victim broadcast back to the
// scheduler, the store handshake toward the LSQ, mispredict flush and halt.
// Tags are 1-based: ROB index i maps to tag i+1, tag 0 means "none".
module rob_commit #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  int                  rob_count,
  input  logic                head_ready,
  input  logic [REG_BITS-1:0] head_rd,
  input  logic [DATA_W-1:0]   head_value,
  input  logic                head_is_store,
  input  logic                head_is_ecall,
  input  logic                head_mispredict,
  input  logic [DATA_W-1:0]   head_target,
  input  logic                st_ack,
  output int                  rob_head,
  output logic                rob_pop,
  output logic                st_req,
  output logic                rf_we,
  output logic [REG_BITS-1:0] rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [REG_BITS-1:0] victim_regstr,
  output logic [DATA_W-1:0]   victim_value,
  output int                  victim_tag,
  output logic                flush,
  output logic [DATA_W-1:0]   redirect_pc,
  output logic                halt
);

  localparam int unsigned IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
  localparam logic [IDX_W-1:0] HEAD_LAST = IDX_W'(ROB_SIZE - 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    HALT       = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] head_inc;
  logic             commit_ok;
  logic             rd_valid;

  // Head may retire only while running, non-empty, ready and not in a flush cycle.
  assign commit_ok = (state == RUN) && (rob_count > 0) && head_ready && !flush;

  // Non-store heads retire immediately; a store retires on the cycle its ack arrives.
  assign rob_pop = (commit_ok && !head_is_store) || ((state == STORE_WAIT) && st_ack);

  // Head pointer advance with wrap from the last entry back to zero.
  assign head_inc = (head_q == HEAD_LAST) ? '0 : head_q + IDX_W'(1);

  // Stores never write the register file even if a stale rd is presented.
  assign rd_valid = (head_rd != '0) && !head_is_store;

  assign rob_head = int'({{(32 - IDX_W){1'b0}}, head_q});

  // Retirement state machine and all registered retire outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      head_q        <= '0;
      st_req        <= 1'b0;
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      victim_regstr <= '0;
      victim_value  <= '0;
      victim_tag    <= 0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      halt          <= 1'b0;
    end else begin
      // Single-cycle pulses default low every cycle.
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      victim_regstr <= '0;
      victim_value  <= '0;
      victim_tag    <= 0;
      flush         <= 1'b0;
      redirect_pc   <= '0;

      case (state)
        RUN: begin
          if (commit_ok && head_is_store) begin
            state  <= STORE_WAIT;
            st_req <= 1'b1;
          end
        end
        STORE_WAIT: begin
          if (st_ack) begin
            state  <= RUN;
            st_req <= 1'b0;
          end
        end
        HALT: begin
          st_req <= 1'b0;
        end
        default: begin
          state  <= RUN;
          st_req <= 1'b0;
        end
      endcase

      if (rob_pop) begin
        head_q     <= head_mispredict ? '0 : head_inc;
        victim_tag <= rob_head + 1;
        if (rd_valid) begin
          rf_we         <= 1'b1;
          rf_waddr      <= head_rd;
          rf_wdata      <= head_value;
          victim_regstr <= head_rd;
          victim_value  <= head_value;
        end
        if (head_mispredict) begin
          flush       <= 1'b1;
          redirect_pc <= head_target;
        end
        if (head_is_ecall) begin
          halt  <= 1'b1;
          state <= HALT;
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: each retiring entry pushes its expected
// retire result; a negedge monitor pops and compares the cycle after rob_pop.
module tb_rob_commit;

  localparam int ROB_SIZE = 16;

  logic        clk = 1'b0;
  logic        reset;
  int          rob_count;
  logic        head_ready;
  logic [4:0]  head_rd;
  logic [31:0] head_value;
  logic        head_is_store;
  logic        head_is_ecall;
  logic        head_mispredict;
  logic [31:0] head_target;
  logic        st_ack;
  int          rob_head;
  logic        rob_pop;
  logic        st_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  victim_regstr;
  logic [31:0] victim_value;
  int          victim_tag;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        halt;

  rob_commit #(.ROB_SIZE(16), .REG_BITS(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .rob_count(rob_count), .head_ready(head_ready),
    .head_rd(head_rd), .head_value(head_value), .head_is_store(head_is_store),
    .head_is_ecall(head_is_ecall), .head_mispredict(head_mispredict),
    .head_target(head_target), .st_ack(st_ack), .rob_head(rob_head),
    .rob_pop(rob_pop), .st_req(st_req), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .victim_regstr(victim_regstr), .victim_value(victim_value),
    .victim_tag(victim_tag), .flush(flush), .redirect_pc(redirect_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          vtag;
    logic        flush;
    logic [31:0] rpc;
    int          head;
    logic        halt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_head = 0;
  logic halt_model = 1'b0;
  logic prev_pop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    rob_count = 0; head_ready = 0; head_rd = '0; head_value = '0;
    head_is_store = 0; head_is_ecall = 0; head_mispredict = 0;
    head_target = '0; st_ack = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] val,
                          input logic mis, input logic [31:0] tgt, input logic ec);
    exp_t e;
    e.rf_we = (rd != 0);
    e.waddr = rd;
    e.wdata = val;
    e.vtag  = exp_head + 1;
    e.flush = mis;
    e.rpc   = tgt;
    exp_head = mis ? 0 : (exp_head + 1) % ROB_SIZE;
    e.head  = exp_head;
    halt_model = halt_model | ec;
    e.halt  = halt_model;
    sb.push_back(e);
  endtask

  // Present one ready non-store head for a cycle; it must pop in that cycle.
  task automatic retire(input logic [4:0] rd, input logic [31:0] val,
                        input logic mis, input logic [31:0] tgt, input logic ec);
    push_exp(rd, val, mis, tgt, ec);
    rob_count = 1; head_ready = 1; head_rd = rd; head_value = val;
    head_mispredict = mis; head_target = tgt; head_is_ecall = ec;
    #1 chk("pop_same_cycle", 32'(rob_pop), 32'd1);
    step();
    set_idle();
  endtask

  // Compare registered retire results on the cycle after each observed pop.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_pop = 1'b0;
    end else begin
      if (prev_pop) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", 32'(prev_pop), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rf_we", 32'(rf_we), 32'(e.rf_we));
          if (e.rf_we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
            chk("rf_wdata", rf_wdata, e.wdata);
            chk("victim_regstr", 32'(victim_regstr), 32'(e.waddr));
            chk("victim_value", victim_value, e.wdata);
            chk("victim_tag", 32'(victim_tag), 32'(e.vtag));
          end else begin
            chk("victim_regstr_none", 32'(victim_regstr), 32'd0);
          end
          chk("flush", 32'(flush), 32'(e.flush));
          if (e.flush) chk("redirect_pc", redirect_pc, e.rpc);
          chk("rob_head", 32'(rob_head), 32'(e.head));
          chk("halt", 32'(halt), 32'(e.halt));
        end
      end
      prev_pop = rob_pop;
    end
  end

  initial begin
    set_idle();
    reset = 1;
    #12;
    chk("rst_rob_head", 32'(rob_head), 32'd0);
    chk("rst_st_req", 32'(st_req), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_victim_tag", 32'(victim_tag), 32'd0);
    step();
    reset = 0;
    step();

    // Basic retire of rd=5, tag 1.
    retire(5'd5, 32'hDEAD, 1'b0, 32'h0, 1'b0);

    // Empty ROB with a stale-high ready must not pop.
    rob_count = 0; head_ready = 1; head_rd = 5'd3;
    #1 chk("empty_no_pop", 32'(rob_pop), 32'd0);
    step();
    set_idle();

    // Store at head, ack after three cycles of st_req.
    rob_count = 1; head_ready = 1; head_is_store = 1;
    #1 chk("store_no_early_pop", 32'(rob_pop), 32'd0);
    step();
    chk("st_req_c1", 32'(st_req), 32'd1);
    chk("store_wait_no_pop", 32'(rob_pop), 32'd0);
    step();
    chk("st_req_c2", 32'(st_req), 32'd1);
    step();
    chk("st_req_c3", 32'(st_req), 32'd1);
    push_exp(5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    st_ack = 1;
    #1 chk("store_pop_on_ack", 32'(rob_pop), 32'd1);
    step();
    chk("st_req_drop", 32'(st_req), 32'd0);
    set_idle();

    // Back-to-back retires walk the head up to the last entry.
    for (int i = 0; i < 13; i++) begin
      retire((i == 6) ? 5'd0 : 5'(i + 2), $urandom, 1'b0, 32'h0, 1'b0);
    end

    // Head at the last entry: tag 16, head wraps to 0.
    retire(5'd7, 32'h7777_0007, 1'b0, 32'h0, 1'b0);

    // JALR-style mispredict with link register: write and flush together.
    retire(5'd3, 32'h3333, 1'b0, 32'h0, 1'b0);
    retire(5'd1, 32'h1234, 1'b1, 32'h400, 1'b0);
    rob_count = 2; head_ready = 1; head_rd = 5'd9;
    #1 chk("flush_cycle_no_pop", 32'(rob_pop), 32'd0);
    step();
    set_idle();
    chk("flush_one_cycle", 32'(flush), 32'd0);

    // Ecall retires, later ready entries are held off.
    retire(5'd2, 32'd55, 1'b0, 32'h0, 1'b1);
    rob_count = 2; head_ready = 1; head_rd = 5'd4;
    for (int i = 0; i < 3; i++) begin
      #1 chk("halt_no_pop", 32'(rob_pop), 32'd0);
      step();
    end
    chk("halt_sticky", 32'(halt), 32'd1);
    set_idle();

    // Reset clears halt.
    reset = 1;
    #1;
    chk("rst2_halt", 32'(halt), 32'd0);
    chk("rst2_rob_head", 32'(rob_head), 32'd0);
    exp_head = 0;
    halt_model = 1'b0;
    step();
    reset = 0;
    step();

    // Ack outside STORE_WAIT is ignored.
    st_ack = 1;
    #1 chk("stray_ack_no_pop", 32'(rob_pop), 32'd0);
    step();
    chk("stray_ack_no_req", 32'(st_req), 32'd0);
    set_idle();

    // Reset in the middle of STORE_WAIT.
    retire(5'd6, 32'h6666, 1'b0, 32'h0, 1'b0);
    rob_count = 1; head_ready = 1; head_is_store = 1;
    step();
    chk("st_req_before_rst", 32'(st_req), 32'd1);
    step();
    #2 reset = 1;
    #1;
    chk("rst_async_st_req", 32'(st_req), 32'd0);
    chk("rst_async_head", 32'(rob_head), 32'd0);
    exp_head = 0;
    set_idle();
    step();
    reset = 0;
    st_ack = 1;
    #1 chk("late_ack_no_pop", 32'(rob_pop), 32'd0);
    step();
    chk("late_ack_no_req", 32'(st_req), 32'd0);
    set_idle();

    // Normal retirement resumes from index 0.
    retire(5'd8, 32'd99, 1'b0, 32'h0, 1'b0);
    step();
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
